// File: rtl/ika87ad_mcseq.sv
// ika87ad_mcseq -- microcode sequencer
//
// Sequences the microcode words of one decoded opcode. It requests an opcode,
// loads the entry address, then for each word strobes the ROM, latches the
// returned word, and pulses an execute strobe. The two-bit bus code in the
// low bits of each word chooses what happens next:
//   00 RD4  end of instruction, go back and ask for a new opcode
//   01 RD3  operand read bus cycle, wait for the bus unit
//   10 WR3  operand write bus cycle, wait for the bus unit
//   11 IDLE internal step, move straight on to the next word
// Every output comes straight from a flop. Next-state logic computes each
// output from the state being entered, so the outputs line up with that state.
//
// Ports:
//   i_CLK              system clock, rising edge
//   i_RST              synchronous active-high reset
//   o_OPCODE_REQ       request next opcode from the fetch/decode stage
//   i_OPCODE_VALID     opcode decoded, i_MC_ENTRY valid
//   i_MC_ENTRY[7:0]    microcode entry address of the decoded opcode
//   o_MCROM_READ_TICK  microcode ROM read strobe
//   o_MCROM_ADDR[7:0]  microcode ROM address
//   i_MCROM_DATA[17:0] ROM word, valid the cycle after the read strobe
//   o_MC_WORD[17:0]    latched microcode word for the datapath
//   o_MC_EXEC          one-cycle strobe: execute o_MC_WORD
//   o_MC_STEP[3:0]     index of the current word within the instruction
//   o_BUS_REQ          bus cycle request to the bus unit
//   o_BUS_TYPE[1:0]    requested bus cycle code, 2'b11 when idle
//   i_BUS_DONE         bus unit has completed the requested cycle

module ika87ad_mcseq (
    input  logic        i_CLK,
    input  logic        i_RST,
    output logic        o_OPCODE_REQ,
    input  logic        i_OPCODE_VALID,
    input  logic [7:0]  i_MC_ENTRY,
    output logic        o_MCROM_READ_TICK,
    output logic [7:0]  o_MCROM_ADDR,
    input  logic [17:0] i_MCROM_DATA,
    output logic [17:0] o_MC_WORD,
    output logic        o_MC_EXEC,
    output logic [3:0]  o_MC_STEP,
    output logic        o_BUS_REQ,
    output logic [1:0]  o_BUS_TYPE,
    input  logic        i_BUS_DONE
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_TICK,
        S_LOAD,
        S_EXEC,
        S_BUS
    } state_t;

    localparam logic [1:0] BC_RD4  = 2'b00;
    localparam logic [1:0] BC_RD3  = 2'b01;
    localparam logic [1:0] BC_WR3  = 2'b10;
    localparam logic [1:0] BC_IDLE = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  step_q, step_d;
    logic [17:0] word_q, word_d;
    logic        opcodeReq_q, opcodeReq_d;
    logic        tick_q, tick_d;
    logic        exec_q, exec_d;
    logic        busReq_q, busReq_d;
    logic [1:0]  busType_q, busType_d;

    logic [7:0]  addrInc;
    logic [3:0]  stepInc;

    // Moving on to the next word: the address wraps naturally at 8 bits, the
    // step counter sticks at 15 so long sequences never alias to a low index.
    assign addrInc = addr_q + 8'd1;
    assign stepInc = (step_q == 4'hF) ? 4'hF : step_q + 4'd1;

    // Next-state logic. The registered outputs are derived from the state
    // being entered, so each strobe is high for exactly the cycle spent in
    // its state. The bus type reuses word_d, which only changes in S_LOAD and
    // therefore equals the held word whenever S_BUS is entered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        step_d  = step_q;
        word_d  = word_q;

        unique case (state_q)
            S_FETCH: begin
                if (i_OPCODE_VALID) begin
                    addr_d  = i_MC_ENTRY;
                    step_d  = 4'd0;
                    state_d = S_TICK;
                end
            end
            S_TICK: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                word_d  = i_MCROM_DATA;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (word_q[1:0])
                    BC_RD4:         state_d = S_FETCH;
                    BC_RD3, BC_WR3: state_d = S_BUS;
                    BC_IDLE: begin
                        addr_d  = addrInc;
                        step_d  = stepInc;
                        state_d = S_TICK;
                    end
                    default:        state_d = S_FETCH;
                endcase
            end
            S_BUS: begin
                if (i_BUS_DONE) begin
                    addr_d  = addrInc;
                    step_d  = stepInc;
                    state_d = S_TICK;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        opcodeReq_d = (state_d == S_FETCH);
        tick_d      = (state_d == S_TICK);
        exec_d      = (state_d == S_EXEC);
        busReq_d    = (state_d == S_BUS);
        busType_d   = busReq_d ? word_d[1:0] : 2'b11;
    end

    // State and output registers. Reset wins from any state, which also drops
    // any bus request that was still waiting for completion.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= S_FETCH;
            addr_q      <= 8'h00;
            step_q      <= 4'h0;
            word_q      <= 18'h00000;
            opcodeReq_q <= 1'b1;
            tick_q      <= 1'b0;
            exec_q      <= 1'b0;
            busReq_q    <= 1'b0;
            busType_q   <= 2'b11;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            word_q      <= word_d;
            opcodeReq_q <= opcodeReq_d;
            tick_q      <= tick_d;
            exec_q      <= exec_d;
            busReq_q    <= busReq_d;
            busType_q   <= busType_d;
        end
    end

    assign o_OPCODE_REQ      = opcodeReq_q;
    assign o_MCROM_READ_TICK = tick_q;
    assign o_MCROM_ADDR      = addr_q;
    assign o_MC_WORD         = word_q;
    assign o_MC_EXEC         = exec_q;
    assign o_MC_STEP         = step_q;
    assign o_BUS_REQ         = busReq_q;
    assign o_BUS_TYPE        = busType_q;

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// tb_ika87ad_mcseq -- testbench for the microcode sequencer
//
// A ROM image lives in the bench. The ROM answers one cycle after each read
// strobe and drives random garbage at all other times, so the latched word is
// only right if it is captured in the correct cycle. A reference model tracks
// the instruction at the level of "which word, which phase of that word" and
// is compared against every output on every falling edge. Directed sequences
// with literal expectations come first, then a long randomized run.

module tb_ika87ad_mcseq;

    logic        clock;
    logic        i_RST;
    logic        i_OPCODE_VALID;
    logic [7:0]  i_MC_ENTRY;
    logic [17:0] i_MCROM_DATA;
    logic        i_BUS_DONE;
    logic        o_OPCODE_REQ;
    logic        o_MCROM_READ_TICK;
    logic [7:0]  o_MCROM_ADDR;
    logic [17:0] o_MC_WORD;
    logic        o_MC_EXEC;
    logic [3:0]  o_MC_STEP;
    logic        o_BUS_REQ;
    logic [1:0]  o_BUS_TYPE;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    logic [17:0] rom [256];

    ika87ad_mcseq dut (
        .i_CLK             (clock),
        .i_RST             (i_RST),
        .o_OPCODE_REQ      (o_OPCODE_REQ),
        .i_OPCODE_VALID    (i_OPCODE_VALID),
        .i_MC_ENTRY        (i_MC_ENTRY),
        .o_MCROM_READ_TICK (o_MCROM_READ_TICK),
        .o_MCROM_ADDR      (o_MCROM_ADDR),
        .i_MCROM_DATA      (i_MCROM_DATA),
        .o_MC_WORD         (o_MC_WORD),
        .o_MC_EXEC         (o_MC_EXEC),
        .o_MC_STEP         (o_MC_STEP),
        .o_BUS_REQ         (o_BUS_REQ),
        .o_BUS_TYPE        (o_BUS_TYPE),
        .i_BUS_DONE        (i_BUS_DONE)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ROM behaviour: the word for the strobed address is presented during the
    // cycle after the strobe, random data otherwise.
    bit         prevTick = 1'b0;
    logic [7:0] prevAddr = 8'h00;
    always @(negedge clock) begin
        if (prevTick) i_MCROM_DATA = rom[prevAddr];
        else          i_MCROM_DATA = 18'($urandom);
        prevTick = (o_MCROM_READ_TICK === 1'b1);
        prevAddr = o_MCROM_ADDR;
    end

    // Reference model. An instruction is a walk through ROM words; each word
    // spends one cycle being read, one being loaded, one executing, and then
    // optionally some cycles on the bus.
    localparam int PH_READ = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_EXEC = 2;
    localparam int PH_BUS  = 3;

    bit          mWaiting = 1'b1;
    int          mPhase   = PH_READ;
    logic [7:0]  mAddr    = 8'h00;
    int          mStep    = 0;
    logic [17:0] mWord    = 18'h0;

    function automatic void nextWord();
        mAddr  = mAddr + 8'd1;
        mStep  = (mStep >= 15) ? 15 : mStep + 1;
        mPhase = PH_READ;
    endfunction

    always @(posedge clock) begin
        if (i_RST) begin
            mWaiting = 1'b1;
            mAddr    = 8'h00;
            mStep    = 0;
            mWord    = 18'h0;
        end else if (mWaiting) begin
            if (i_OPCODE_VALID) begin
                mWaiting = 1'b0;
                mAddr    = i_MC_ENTRY;
                mStep    = 0;
                mPhase   = PH_READ;
            end
        end else begin
            case (mPhase)
                PH_READ: mPhase = PH_LOAD;
                PH_LOAD: begin
                    mWord  = rom[mAddr];
                    mPhase = PH_EXEC;
                end
                PH_EXEC: begin
                    if (mWord[1:0] == 2'b00)      mWaiting = 1'b1;
                    else if (mWord[1:0] == 2'b11) nextWord();
                    else                          mPhase = PH_BUS;
                end
                default: if (i_BUS_DONE) nextWord();
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (compareOn) begin
            bit onBus;
            onBus = !mWaiting && (mPhase == PH_BUS);
            checkOutput("mdl_opcodeReq", 32'(o_OPCODE_REQ), 32'(mWaiting));
            checkOutput("mdl_tick", 32'(o_MCROM_READ_TICK), 32'(!mWaiting && mPhase == PH_READ));
            checkOutput("mdl_addr", 32'(o_MCROM_ADDR), 32'(mAddr));
            checkOutput("mdl_word", 32'(o_MC_WORD), 32'(mWord));
            checkOutput("mdl_exec", 32'(o_MC_EXEC), 32'(!mWaiting && mPhase == PH_EXEC));
            checkOutput("mdl_step", 32'(o_MC_STEP), 32'(mStep));
            checkOutput("mdl_busReq", 32'(o_BUS_REQ), 32'(onBus));
            checkOutput("mdl_busType", 32'(o_BUS_TYPE), onBus ? 32'(mWord[1:0]) : 32'h3);
        end
    end

    // Drive one cycle of inputs, starting and ending on a falling edge.
    task automatic applyStimulus(input bit rst, input bit valid,
                                 input logic [7:0] entry, input bit done);
        i_RST          = rst;
        i_OPCODE_VALID = valid;
        i_MC_ENTRY     = entry;
        i_BUS_DONE     = done;
        @(negedge clock);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_opcodeReq"}, 32'(o_OPCODE_REQ), 32'h1);
        checkOutput({tag, "_tick"}, 32'(o_MCROM_READ_TICK), 32'h0);
        checkOutput({tag, "_addr"}, 32'(o_MCROM_ADDR), 32'h00);
        checkOutput({tag, "_word"}, 32'(o_MC_WORD), 32'h0);
        checkOutput({tag, "_exec"}, 32'(o_MC_EXEC), 32'h0);
        checkOutput({tag, "_step"}, 32'(o_MC_STEP), 32'h0);
        checkOutput({tag, "_busReq"}, 32'(o_BUS_REQ), 32'h0);
        checkOutput({tag, "_busType"}, 32'(o_BUS_TYPE), 32'h3);
    endtask

    initial begin
        int waitCycles;
        for (int i = 0; i < 256; i++) rom[i] = 18'($urandom);
        rom[8'h40] = {16'h1234, 2'b00};
        rom[8'h10] = {16'hA5A5, 2'b01};
        rom[8'h11] = {16'h0F0F, 2'b00};
        rom[8'hFF] = {16'h3C3C, 2'b11};
        rom[8'h00] = {16'h7777, 2'b00};
        rom[8'h20] = {16'hBEEF, 2'b10};
        for (int i = 8'h80; i < 8'h94; i++) rom[i] = {16'(i), 2'b11};
        rom[8'h94] = {16'h9494, 2'b00};

        i_RST = 1'b1; i_OPCODE_VALID = 1'b0; i_MC_ENTRY = 8'h00; i_BUS_DONE = 1'b0;
        i_MCROM_DATA = 18'h0;
        @(negedge clock);

        // Reset state.
        applyStimulus(1, 0, 8'h00, 0);
        compareOn = 1'b1;
        checkResetValues("rst");

        // Single-word instruction ending in RD4.
        applyStimulus(0, 1, 8'h40, 0);
        checkOutput("rd4_tick", 32'(o_MCROM_READ_TICK), 32'h1);
        checkOutput("rd4_tickAddr", 32'(o_MCROM_ADDR), 32'h40);
        checkOutput("rd4_opcodeReqLow", 32'(o_OPCODE_REQ), 32'h0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("rd4_loadNoExec", 32'(o_MC_EXEC), 32'h0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("rd4_exec", 32'(o_MC_EXEC), 32'h1);
        checkOutput("rd4_word", 32'(o_MC_WORD), 32'h048D0);
        checkOutput("rd4_step", 32'(o_MC_STEP), 32'h0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("rd4_backToFetch", 32'(o_OPCODE_REQ), 32'h1);

        // RD3 operand read held for three cycles; opcode valid pulsed on the bus.
        applyStimulus(0, 1, 8'h10, 0);
        checkOutput("rd3_tickAddr", 32'(o_MCROM_ADDR), 32'h10);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("rd3_word", 32'(o_MC_WORD), 32'h29695);
        applyStimulus(0, 0, 8'h00, 0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("rd3_busReq", 32'(o_BUS_REQ), 32'h1);
            checkOutput("rd3_busType", 32'(o_BUS_TYPE), 32'h1);
            checkOutput("rd3_busAddr", 32'(o_MCROM_ADDR), 32'h10);
            if (c < 2) applyStimulus(0, (c == 0), 8'h77, 0);
        end
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("rd3_nextTick", 32'(o_MCROM_READ_TICK), 32'h1);
        checkOutput("rd3_nextAddr", 32'(o_MCROM_ADDR), 32'h11);
        checkOutput("rd3_busReleased", 32'(o_BUS_REQ), 32'h0);
        checkOutput("rd3_busTypeIdle", 32'(o_BUS_TYPE), 32'h3);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("rd3_exec2", 32'(o_MC_EXEC), 32'h1);
        checkOutput("rd3_step1", 32'(o_MC_STEP), 32'h1);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("rd3_fetch", 32'(o_OPCODE_REQ), 32'h1);

        // Bus done pulsed while waiting for an opcode changes nothing.
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("idleDone_opcodeReq", 32'(o_OPCODE_REQ), 32'h1);
        checkOutput("idleDone_tick", 32'(o_MCROM_READ_TICK), 32'h0);
        checkOutput("idleDone_addr", 32'(o_MCROM_ADDR), 32'h11);
        checkOutput("idleDone_step", 32'(o_MC_STEP), 32'h1);

        // IDLE word at 8'hFF wraps the address.
        applyStimulus(0, 1, 8'hFF, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("wrap_exec", 32'(o_MC_EXEC), 32'h1);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("wrap_tick", 32'(o_MCROM_READ_TICK), 32'h1);
        checkOutput("wrap_addr", 32'(o_MCROM_ADDR), 32'h00);
        checkOutput("wrap_step", 32'(o_MC_STEP), 32'h1);
        checkOutput("wrap_noBus", 32'(o_BUS_REQ), 32'h0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("wrap_fetch", 32'(o_OPCODE_REQ), 32'h1);

        // Reset while a WR3 bus cycle is pending.
        applyStimulus(0, 1, 8'h20, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("wr3_busReq", 32'(o_BUS_REQ), 32'h1);
        checkOutput("wr3_busType", 32'(o_BUS_TYPE), 32'h2);
        applyStimulus(1, 0, 8'h00, 0);
        checkResetValues("wr3Rst");

        // Twenty-one word instruction: the step counter saturates at 15.
        applyStimulus(0, 1, 8'h80, 0);
        waitCycles = 0;
        while (o_OPCODE_REQ !== 1'b1 && waitCycles < 200) begin
            applyStimulus(0, 0, 8'h00, 0);
            waitCycles++;
        end
        checkOutput("sat_finished", 32'(o_OPCODE_REQ), 32'h1);
        checkOutput("sat_step", 32'(o_MC_STEP), 32'hF);
        checkOutput("sat_addr", 32'(o_MCROM_ADDR), 32'h94);

        // Randomized run against the model.
        for (int i = 0; i < 256; i++) rom[i] = 18'($urandom);
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 99) < 2), $urandom_range(0, 1),
                          8'($urandom), ($urandom_range(0, 9) < 4));
        end

        compareOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
